// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: coin denominations
// and the payout controller states.
package change_dispenser_pkg;

  localparam int unsigned DENOM_W     = 2;
  localparam int unsigned DENOM_VAL_W = 6;
  localparam int unsigned NUM_DENOM   = 4;

  typedef enum logic [DENOM_W-1:0] {
    D1  = 2'd0,
    D5  = 2'd1,
    D10 = 2'd2,
    D50 = 2'd3
  } denom_e;

  localparam logic [DENOM_VAL_W-1:0] VAL_D1  = 6'd1;
  localparam logic [DENOM_VAL_W-1:0] VAL_D5  = 6'd5;
  localparam logic [DENOM_VAL_W-1:0] VAL_D10 = 6'd10;
  localparam logic [DENOM_VAL_W-1:0] VAL_D50 = 6'd50;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    FINISH   = 2'd3
  } state_e;

  function automatic logic [DENOM_VAL_W-1:0] denom_value(input denom_e d);
    case (d)
      D1:      denom_value = VAL_D1;
      D5:      denom_value = VAL_D5;
      D10:     denom_value = VAL_D10;
      default: denom_value = VAL_D50;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_stock_counter.sv
// Per-denomination coin stock: loads to STOCK_INIT, counts down one coin per
// ejection, and flags empty in the same cycle the count reaches zero.
module coin_stock_counter #(
  parameter int unsigned STOCK_W    = 8,
  parameter int unsigned STOCK_INIT = 20
) (
  input  logic clk,
  input  logic i_load,
  input  logic i_dec,
  output logic o_empty
);

  logic [STOCK_W-1:0] r_count;
  logic               r_empty;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_count <= STOCK_W'(STOCK_INIT);
      r_empty <= (STOCK_INIT == 0);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - STOCK_W'(1);
      r_empty <= (r_count == STOCK_W'(1));
    end
  end

  assign o_empty = r_empty;

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout controller: pays a change amount via the hopper using
// 50/10/5/1 coins limited by on-chip stock, and reports any shortfall.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned AMT_W      = 8,
  parameter int unsigned STOCK_W    = 8,
  parameter int unsigned STOCK_INIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  input  logic             refill,
  output logic             hopper_req,
  output logic [1:0]       hopper_sel,
  input  logic             hopper_ack,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [3:0]       stock_empty
);

  state_e           r_state;
  logic [AMT_W-1:0] r_remaining;
  denom_e           r_sel;
  logic             r_ready;
  logic             r_req;
  logic             r_done;
  logic [AMT_W-1:0] r_shortfall;

  logic             w_load;
  logic [3:0]       w_dec;
  logic [3:0]       w_empty;
  logic             w_found;
  denom_e           w_pick;
  logic [AMT_W-1:0] w_rem_next;

  assign w_load     = reset | (refill & (r_state == IDLE));
  assign w_rem_next = r_remaining - AMT_W'(denom_value(r_sel));

  for (genvar g = 0; g < NUM_DENOM; g++) begin : g_stock
    assign w_dec[g] = (r_state == DISPENSE) & hopper_ack & (r_sel == denom_e'(2'(g)));

    coin_stock_counter #(
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
    ) u_stock (
      .clk     (clk),
      .i_load  (w_load),
      .i_dec   (w_dec[g]),
      .o_empty (w_empty[g])
    );
  end

  // Scan small to large so the last hit is the largest payable coin in stock.
  always_comb begin
    w_found = 1'b0;
    w_pick  = D1;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (!w_empty[i] && (AMT_W'(denom_value(denom_e'(2'(i)))) <= r_remaining)) begin
        w_found = 1'b1;
        w_pick  = denom_e'(2'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_sel       <= D1;
      r_ready     <= 1'b1;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
      r_shortfall <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (change_valid) begin
            r_remaining <= change_amount;
            r_ready     <= 1'b0;
            if (change_amount == '0) begin
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_shortfall <= '0;
            end else begin
              r_state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_req   <= 1'b1;
            r_state <= DISPENSE;
          end else begin
            r_state     <= FINISH;
            r_done      <= 1'b1;
            r_shortfall <= r_remaining;
          end
        end
        DISPENSE: begin
          if (hopper_ack) begin
            r_req       <= 1'b0;
            r_remaining <= w_rem_next;
            if (w_rem_next == '0) begin
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_shortfall <= '0;
            end else begin
              r_state <= SELECT;
            end
          end
        end
        FINISH: begin
          r_done      <= 1'b0;
          r_shortfall <= '0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign change_ready = r_ready;
  assign hopper_req   = r_req;
  assign hopper_sel   = r_sel;
  assign done         = r_done;
  assign shortfall    = r_shortfall;
  assign stock_empty  = w_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy-payout reference
// model that tracks coin stock with plain arithmetic.
module tb_change_dispenser;

  localparam int unsigned AMT_W    = 8;
  localparam int unsigned STOCK_W  = 8;
  localparam int unsigned TB_STOCK = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             change_valid = 1'b0;
  logic [AMT_W-1:0] change_amount = '0;
  logic             change_ready;
  logic             refill = 1'b0;
  logic             hopper_req;
  logic [1:0]       hopper_sel;
  logic             hopper_ack = 1'b0;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic [3:0]       stock_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int m_stock[4];
  int val[4] = '{1, 5, 10, 50};
  int exp_q[$];

  change_dispenser #(
    .AMT_W      (AMT_W),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (TB_STOCK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .refill        (refill),
    .hopper_req    (hopper_req),
    .hopper_sel    (hopper_sel),
    .hopper_ack    (hopper_ack),
    .done          (done),
    .shortfall     (shortfall),
    .stock_empty   (stock_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
    return e;
  endfunction

  task automatic model_restore();
    for (int i = 0; i < 4; i++) m_stock[i] = TB_STOCK;
  endtask

  // Greedy payout by counting: take as many of each coin as value and stock allow.
  task automatic plan(input int amt, output int sf);
    int rem;
    int n;
    exp_q.delete();
    rem = amt;
    for (int d = 3; d >= 0; d--) begin
      n = rem / val[d];
      if (n > m_stock[d]) n = m_stock[d];
      repeat (n) exp_q.push_back(d);
      m_stock[d] -= n;
      rem -= n * val[d];
    end
    sf = rem;
  endtask

  // Entered and left at a falling edge.
  task automatic do_reset();
    reset      = 1'b1;
    hopper_ack = 1'b0;
    change_valid = 1'b0;
    refill     = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(change_ready), 1);
    check("rst_req", 32'(hopper_req), 0);
    check("rst_sel", 32'(hopper_sel), 0);
    check("rst_done", 32'(done), 0);
    check("rst_shortfall", 32'(shortfall), 0);
    check("rst_empty", 32'(stock_empty), 0);
    reset = 1'b0;
    model_restore();
  endtask

  task automatic do_refill();
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    model_restore();
    check("refill_empty", 32'(stock_empty), 32'(exp_empty()));
    check("refill_ready", 32'(change_ready), 1);
  endtask

  task automatic run_txn(input int amt, input bit with_refill, input int dly_lo, input int dly_hi);
    int sf;
    int cnt;
    int d;
    int code;
    check("ready_idle", 32'(change_ready), 1);
    change_valid  = 1'b1;
    change_amount = AMT_W'(amt);
    refill        = with_refill;
    if (with_refill) model_restore();
    plan(amt, sf);
    @(negedge clk);
    change_valid = 1'b0;
    refill       = 1'b0;
    check("ready_busy", 32'(change_ready), 0);
    if (amt == 0) check("zero_done", 32'(done), 1);
    while (exp_q.size() > 0) begin
      code = exp_q.pop_front();
      cnt  = 0;
      while (!hopper_req && !done && cnt < 8) begin
        @(negedge clk);
        cnt++;
      end
      check("coin_req", 32'(hopper_req), 1);
      if (!hopper_req) return;
      check("coin_sel", 32'(hopper_sel), 32'(code));
      d = int'($urandom_range(dly_hi, dly_lo));
      repeat (d) begin
        change_valid  = 1'($urandom_range(1, 0));
        change_amount = AMT_W'($urandom);
        refill        = ($urandom_range(3, 0) == 0);
        @(negedge clk);
        check("req_hold", 32'(hopper_req), 1);
        check("sel_hold", 32'(hopper_sel), 32'(code));
      end
      change_valid = 1'b0;
      refill       = 1'b0;
      hopper_ack   = 1'b1;
      @(negedge clk);
      hopper_ack = 1'b0;
      check("req_drop", 32'(hopper_req), 0);
    end
    cnt = 0;
    while (!done && !hopper_req && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("extra_req", 32'(hopper_req), 0);
    check("done", 32'(done), 1);
    check("shortfall", 32'(shortfall), 32'(sf));
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("sf_clear", 32'(shortfall), 0);
    check("ready_back", 32'(change_ready), 1);
    check("stock_empty", 32'(stock_empty), 32'(exp_empty()));
  endtask

  task automatic wait_req(input int code);
    int cnt = 0;
    while (!hopper_req && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_req", 32'(hopper_req), 1);
    check("mid_sel", 32'(hopper_sel), 32'(code));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    run_txn(0, 1'b0, 0, 0);
    run_txn(67, 1'b0, 0, 0);
    run_txn(10, 1'b0, 3, 3);
    run_txn(100, 1'b0, 0, 1);
    run_txn(100, 1'b0, 0, 1);
    run_txn(100, 1'b0, 0, 1);
    do_refill();
    run_txn(1, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(4, 0) == 0) begin
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        check("stray_ack", 32'(stock_empty), 32'(exp_empty()));
      end
      if ($urandom_range(7, 0) == 0) do_refill();
      run_txn(int'($urandom_range(255, 0)), ($urandom_range(5, 0) == 0), 0, 3);
    end

    // Abort mid-payout: second coin in flight when reset hits.
    do_reset();
    change_valid  = 1'b1;
    change_amount = AMT_W'(60);
    @(negedge clk);
    change_valid = 1'b0;
    wait_req(3);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    wait_req(2);
    do_reset();
    @(negedge clk);
    check("abort_no_done", 32'(done), 0);
    run_txn(255, 1'b0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending-machine controller FSM: accepts one change amount per transaction and pays it out coin by coin through a coin hopper.
- Greedy payout over denominations 50/10/5/1, limited by an on-chip stock count per denomination.
- Reports completion and any unpaid remainder (shortfall) back to the controller.

Parameters:
AMT_W, 8, width of change_amount and shortfall (max 255)
STOCK_W, 8, width of each per-denomination stock counter
STOCK_INIT, 20, coins per denomination after reset or refill; must fit in STOCK_W

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
change_valid  in  1  change request strobe; accepted only when change_ready=1
change_amount  in  AMT_W  change to pay, sampled on accept
change_ready  out  1  high only in IDLE
refill  in  1  restores all stock counters to STOCK_INIT; honoured only in IDLE
hopper_req  out  1  request the hopper to eject one coin of hopper_sel
hopper_sel  out  2  denomination code: 0=1, 1=5, 2=10, 3=50
hopper_ack  in  1  hopper ejected the requested coin (one-cycle pulse)
done  out  1  one-cycle pulse at transaction end
shortfall  out  AMT_W  unpaid remainder; valid while done=1, otherwise 0
stock_empty  out  4  bit i high when stock of denom code i is 0

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE; remaining=0; all stock counters=STOCK_INIT.
  - Outputs: change_ready=1, hopper_req=0, hopper_sel=0, done=0, shortfall=0, stock_empty=0.
- All outputs are Moore outputs, derived from the registered state and datapath. There is no combinational path from any input to any output.
- IDLE:
  - change_ready=1.
  - On change_valid: remaining<=change_amount. If change_amount==0, go to FINISH; otherwise go to SELECT.
  - refill in the same cycle as change_valid: both take effect. The stock is restored, and the request is accepted and uses the refilled stock.
- SELECT (1 cycle):
  - Pick the largest denom d with value(d)<=remaining and stock[d]>0; priority order is 50, 10, 5, 1.
  - If one is found: latch sel<=d and go to DISPENSE.
  - If none is found: go to FINISH with remaining unchanged.
- DISPENSE:
  - hopper_req=1; hopper_sel=sel, held stable until ack.
  - Wait indefinitely for hopper_ack.
  - On hopper_ack: remaining<=remaining-value(sel); stock[sel]<=stock[sel]-1. Then go to FINISH if the new remaining==0, else to SELECT.
  - hopper_req drops in the cycle after ack, even if the next state re-selects the same denom.
- FINISH (1 cycle): done=1, shortfall=remaining; next state IDLE.
- Ignored inputs:
  - hopper_ack outside DISPENSE.
  - change_valid and refill outside IDLE.
- Latency:
  - Zero-amount request accepted at edge N: done high in cycle N+1; change_ready high again in N+2.
  - Each coin costs 1 SELECT cycle plus at least 1 DISPENSE cycle.
- Arithmetic:
  - Subtraction cannot underflow, because selection guarantees value<=remaining.
  - Stock counters never decrement below 0.
  - Denom values are compared at AMT_W width.
- Reset mid-transaction: the FSM aborts to IDLE at the next edge. hopper_req is low from that point. No done pulse; stock is restored to STOCK_INIT.
- stock_empty updates the cycle after the decrement that reaches 0, and the cycle after refill.

Decomposition:
- Shared package:
  - denomination code enum (D1, D5, D10, D50);
  - denom value constants (1, 5, 10, 50);
  - FSM state enum (IDLE, SELECT, DISPENSE, FINISH).
- The controller FSM uses the package for its change interface.
- Sub-module coin_stock_counter, instantiated four times:
  - STOCK_W down-counter with synchronous load to STOCK_INIT (reset/refill), decrement enable, and empty flag.

Test Plan:
- Reset, then change_valid with amount 0 -> done pulse exactly 1 cycle after accept, shortfall=0, hopper_req never asserted.
- Amount 67, full stock, hopper_ack returned the cycle after each req -> hopper_sel sequence 3,2,1,0,0 (50,10,5,1,1), then done with shortfall=0. Stock becomes 50:19, 10:19, 5:19, 1:18.
- Amount 10, hopper_ack delayed 3 cycles -> hopper_req=1 and hopper_sel=2 held stable for all 4 cycles; change_valid pulses during this window are ignored.
- STOCK_INIT=2: request 100 -> 50,50, done shortfall=0, stock_empty[3]=1. Second request 100 -> 10,10,5,5,1,1, then done with shortfall=68 and stock_empty=4'b1111.
- Continue from the depleted state: refill in IDLE -> stock_empty=0 next cycle. Request 1 -> single coin, sel=0, done shortfall=0.
- Reset asserted while in DISPENSE (amount 60, after first ack) -> next cycle hopper_req=0, change_ready=1, no done pulse, all stock=STOCK_INIT.
